fetch_seq: RTL and testbench
============================

Name: fetch_seq

Overview:
- Byte-serial instruction fetch for the Y86-64 SEQ core. It is the consumer side of the PC written by the PC-update stage.
- Accepts a PC, reads the instruction one byte at a time from a byte-wide instruction memory over a req/ack port, and decodes it into icode, ifun, rA, rB, valC and valP.
- Returns the result plus a 2-bit status to the core over a valid/ready handshake.

Parameters:
- IMEM_SIZE, 4096, number of valid instruction-memory bytes; any byte address >= IMEM_SIZE is an address error.

Ports:
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-high reset
- start  in  1  begin a fetch at pc_in; sampled only in IDLE
- pc_in  in  64  address of the instruction's first byte
- busy  out  1  high in FETCH and DONE
- imem_req  out  1  byte read request
- imem_addr  out  64  byte address; stable while imem_req is high and ack is not yet seen
- imem_rdata  in  8  read byte; valid in the cycle imem_ack is high
- imem_ack  in  1  byte delivered this cycle; ignored when imem_req is low
- f_valid  out  1  decoded result available
- f_ready  in  1  consumer accepts the result
- icode  out  4  instruction code
- ifun  out  4  function code
- rA  out  4  register A; 4'hF when absent
- rB  out  4  register B; 4'hF when absent
- valC  out  64  constant, little-endian; 0 when absent
- valP  out  64  pc_in + instruction length
- status  out  2  0 = AOK, 1 = HLT, 2 = ADR, 3 = INS

Behaviour:
- Reset: state IDLE; imem_req, f_valid and busy = 0; imem_addr, icode, ifun, valC and valP = 0; rA and rB = 4'hF; status = 0 (AOK). Reset mid-fetch drops imem_req in the next cycle and discards the partial instruction.
- FSM:
  - IDLE -> FETCH on start; latch pc_in and clear the byte index k to 0.
  - FETCH: before requesting byte k, check pc + k against IMEM_SIZE. If pc + k >= IMEM_SIZE: status = ADR, go to DONE, do not assert req.
  - Otherwise assert imem_req with imem_addr = pc + k. On ack, store the byte and set k = k + 1. After the final byte, go to DONE.
  - DONE: f_valid = 1, outputs held stable until f_ready is high, then go to IDLE. f_valid and f_ready in the same cycle complete the transfer.
- Byte 0 = {icode[7:4], ifun[3:0]}. Instruction length is fixed by icode:
  - 0 (halt), 1 (nop), 9 (ret): 1 byte.
  - 2 (rrmovq/cmovXX), 6 (OPq), A (pushq), B (popq): 2 bytes.
  - 7 (jXX), 8 (call): 9 bytes; valC = bytes 1..8.
  - 3 (irmovq), 4 (rmmovq), 5 (mrmovq): 10 bytes; byte 1 = {rA, rB}; valC = bytes 2..9.
  - valC is little-endian: the lowest address is the least-significant byte.
- Validity check, decided after byte 0:
  - icode > B is invalid.
  - ifun must be 0 for icodes 0, 1, 3, 4, 5, 8, 9, A, B.
  - ifun must be <= 6 for icodes 2 and 7.
  - ifun must be <= 3 for icode 6.
  - An invalid byte 0 gives status = INS and goes straight to DONE with no further requests; valP = pc + 1.
- icode 0 completes with status = HLT and valP = pc + 1. All other valid instructions complete with AOK.
- ADR takes priority over INS; no byte is requested past the first error. On ADR, valP = pc + k, where k is the offending byte index.
- valP uses 64-bit wraparound addition. Because ADR is checked first, no request is issued at a wrapped address.
- Timing with a zero-wait memory (ack in the same cycle as req): start sampled in cycle t; byte k is requested in cycle t+1+k; f_valid rises in cycle t+1+len. Each cycle of ack-low wait adds one cycle.
- start is ignored while busy is high.
- Fields not yet fetched keep their reset defaults for the current instruction, i.e. they are cleared at the IDLE -> FETCH transition.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (I_HALT .. I_POPQ);
  - status codes (S_AOK, S_HLT, S_ADR, S_INS);
  - function ilen(icode) returning 1, 2, 9 or 10;
  - function ifun_ok(icode, ifun).
- One natural sub-module, fetch_byte_asm: shift-assembles the bytes into {rA, rB, valC} using the byte index and the has_regs flag.

Test Plan:
- Memory {0x30, 0xF2, 0x0A, 0, 0, 0, 0, 0, 0, 0} at pc 0x0, zero-wait -> after 10 requests: icode 3, ifun 0, rA F, rB 2, valC 0x0A, valP 0xA, status AOK, f_valid at t+11.
- call at pc 0x20, bytes {0x80, 0x78, 0x56, 0x34, 0x12, 0, 0, 0, 0}, ack delayed 2 cycles per byte -> valC 0x12345678, rA = rB = F, valP 0x29; addr stable during waits.
- Byte 0x00 at pc 0x40 -> status HLT, valP 0x41, exactly one request. Byte 0xC0 -> INS. Byte 0x27 -> INS (ifun 7 > 6).
- irmovq at pc IMEM_SIZE-4 -> 4 bytes fetched, then status ADR, valP = IMEM_SIZE, no request at IMEM_SIZE.
- Hold f_ready low for 5 cycles in DONE -> outputs stable, start ignored; f_ready high -> IDLE. Assert rst during byte 3 of rmmovq -> imem_req low next cycle, f_valid never rises, all outputs at reset values.

Source files
------------

// File: rtl/fetch_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------
// y86_pkg : Y86-64 icode/status constants and fetch decode helpers
// Rev 1.0
// ----------------------------------------------------------------------
package y86_pkg;

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_NOP    = 4'h1;
  localparam logic [3:0] I_RRMOVQ = 4'h2;
  localparam logic [3:0] I_IRMOVQ = 4'h3;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_OPQ    = 4'h6;
  localparam logic [3:0] I_JXX    = 4'h7;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [1:0] S_AOK = 2'd0;
  localparam logic [1:0] S_HLT = 2'd1;
  localparam logic [1:0] S_ADR = 2'd2;
  localparam logic [1:0] S_INS = 2'd3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DONE  = 2'd2
  } fetch_state_e;

  function automatic logic [3:0] ilen(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_OPQ, I_PUSHQ, I_POPQ: ilen = 4'd2;
      I_JXX, I_CALL:                    ilen = 4'd9;
      I_IRMOVQ, I_RMMOVQ, I_MRMOVQ:     ilen = 4'd10;
      default:                          ilen = 4'd1;
    endcase
  endfunction

  function automatic logic ifun_ok(input logic [3:0] icode, input logic [3:0] ifun);
    case (icode)
      I_RRMOVQ, I_JXX: ifun_ok = (ifun <= 4'd6);
      I_OPQ:           ifun_ok = (ifun <= 4'd3);
      I_HALT, I_NOP, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_CALL, I_RET, I_PUSHQ, I_POPQ:
                       ifun_ok = (ifun == 4'd0);
      default:         ifun_ok = 1'b0;
    endcase
  endfunction

  function automatic logic has_regs(input logic [3:0] icode);
    case (icode)
      I_RRMOVQ, I_IRMOVQ, I_RMMOVQ, I_MRMOVQ,
      I_OPQ, I_PUSHQ, I_POPQ: has_regs = 1'b1;
      default:                has_regs = 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/fetch_seq_if.sv
`default_nettype none
// ----------------------------------------------------------------------
// fetch_seq_if : core handshake, imem port and decoded result bundle
// Rev 1.0
// ----------------------------------------------------------------------
interface fetch_seq_if;
  logic        start;
  logic [63:0] pc_in;
  logic        busy;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [7:0]  imem_rdata;
  logic        imem_ack;
  logic        f_valid;
  logic        f_ready;
  logic [3:0]  icode;
  logic [3:0]  ifun;
  logic [3:0]  rA;
  logic [3:0]  rB;
  logic [63:0] valC;
  logic [63:0] valP;
  logic [1:0]  status;

  modport master (
    output start, pc_in, imem_rdata, imem_ack, f_ready,
    input  busy, imem_req, imem_addr, f_valid,
    input  icode, ifun, rA, rB, valC, valP, status
  );

  modport slave (
    input  start, pc_in, imem_rdata, imem_ack, f_ready,
    output busy, imem_req, imem_addr, f_valid,
    output icode, ifun, rA, rB, valC, valP, status
  );
endinterface
`default_nettype wire

// File: rtl/fetch_seq_byte_asm.sv
`default_nettype none
// ----------------------------------------------------------------------
// fetch_byte_asm : places fetched bytes 1..9 into {rA, rB, valC}
// Rev 1.0
// ----------------------------------------------------------------------
module fetch_byte_asm
  import y86_pkg::*;
(
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        clr_i,
  input  wire logic        we_i,
  input  wire logic [3:0]  k_i,
  input  wire logic [3:0]  icode_i,
  input  wire logic [7:0]  byte_i,
  output logic [3:0]       ra_o,
  output logic [3:0]       rb_o,
  output logic [63:0]      valc_o
);

  logic [3:0]  ra_q;
  logic [3:0]  rb_q;
  logic [63:0] valc_q;
  logic        regs_d;
  logic [3:0]  lane_d;

  // valC lane = byte index minus the opcode byte and, if present, the register byte
  always_comb begin
    regs_d = has_regs(icode_i);
    lane_d = k_i - (regs_d ? 4'd2 : 4'd1);
  end

  always_ff @(posedge clk) begin
    if (rst || clr_i) begin
      ra_q   <= 4'hF;
      rb_q   <= 4'hF;
      valc_q <= 64'd0;
    end else if (we_i) begin
      if (regs_d && (k_i == 4'd1)) begin
        ra_q <= byte_i[7:4];
        rb_q <= byte_i[3:0];
      end else begin
        valc_q[8*lane_d +: 8] <= byte_i;
      end
    end
  end

  assign ra_o   = ra_q;
  assign rb_o   = rb_q;
  assign valc_o = valc_q;

endmodule
`default_nettype wire

// File: rtl/fetch_seq.sv
`default_nettype none
// ----------------------------------------------------------------------
// fetch_seq : byte-serial Y86-64 SEQ instruction fetch and decode
// Rev 1.0
// ----------------------------------------------------------------------
module fetch_seq
  import y86_pkg::*;
#(
  parameter int IMEM_SIZE = 4096
) (
  input wire logic   clk,
  input wire logic   rst,
  fetch_seq_if.slave bus
);

  localparam logic [63:0] c_imem_limit = 64'(IMEM_SIZE);

  fetch_state_e state_q;
  logic [63:0]  pc_q;
  logic [3:0]   k_q;
  logic [3:0]   icode_q;
  logic [3:0]   ifun_q;
  logic [63:0]  valp_q;
  logic [1:0]   status_q;
  logic         req_q;
  logic [63:0]  addr_q;
  logic         valid_q;
  logic         busy_q;

  logic [3:0]   k_next_d;
  logic [63:0]  addr_next_d;
  logic [3:0]   len_d;
  logic         byte0_ok_d;
  logic         halt_d;
  logic         byte_ack_d;

  logic [3:0]   w_ra;
  logic [3:0]   w_rb;
  logic [63:0]  w_valc;

  // While byte 0 is arriving the length comes from the byte itself
  always_comb begin
    k_next_d    = k_q + 4'd1;
    addr_next_d = pc_q + {60'd0, k_next_d};
    len_d       = ilen((k_q == 4'd0) ? bus.imem_rdata[7:4] : icode_q);
    byte0_ok_d  = ifun_ok(bus.imem_rdata[7:4], bus.imem_rdata[3:0]);
    halt_d      = (k_q == 4'd0) && (bus.imem_rdata[7:4] == I_HALT);
    byte_ack_d  = (state_q == ST_FETCH) && bus.imem_ack;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      pc_q     <= 64'd0;
      k_q      <= 4'd0;
      icode_q  <= 4'd0;
      ifun_q   <= 4'd0;
      valp_q   <= 64'd0;
      status_q <= S_AOK;
      req_q    <= 1'b0;
      addr_q   <= 64'd0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.start) begin
            pc_q     <= bus.pc_in;
            k_q      <= 4'd0;
            icode_q  <= 4'd0;
            ifun_q   <= 4'd0;
            valp_q   <= 64'd0;
            status_q <= S_AOK;
            busy_q   <= 1'b1;
            if (bus.pc_in >= c_imem_limit) begin
              status_q <= S_ADR;
              valp_q   <= bus.pc_in;
              valid_q  <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              req_q    <= 1'b1;
              addr_q   <= bus.pc_in;
              state_q  <= ST_FETCH;
            end
          end
        end
        ST_FETCH: begin
          if (bus.imem_ack) begin
            if (k_q == 4'd0) begin
              icode_q <= bus.imem_rdata[7:4];
              ifun_q  <= bus.imem_rdata[3:0];
            end
            if ((k_q == 4'd0) && !byte0_ok_d) begin
              status_q <= S_INS;
              valp_q   <= addr_next_d;
              req_q    <= 1'b0;
              valid_q  <= 1'b1;
              state_q  <= ST_DONE;
            end else if (k_next_d == len_d) begin
              status_q <= halt_d ? S_HLT : S_AOK;
              valp_q   <= addr_next_d;
              req_q    <= 1'b0;
              valid_q  <= 1'b1;
              state_q  <= ST_DONE;
            end else if (addr_next_d >= c_imem_limit) begin
              // Next byte would fall outside imem: stop before requesting it
              status_q <= S_ADR;
              valp_q   <= addr_next_d;
              req_q    <= 1'b0;
              valid_q  <= 1'b1;
              state_q  <= ST_DONE;
            end else begin
              addr_q <= addr_next_d;
              k_q    <= k_next_d;
            end
          end
        end
        ST_DONE: begin
          if (bus.f_ready) begin
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  fetch_byte_asm u_asm (
    .clk     (clk),
    .rst     (rst),
    .clr_i   ((state_q == ST_IDLE) && bus.start),
    .we_i    (byte_ack_d && (k_q != 4'd0)),
    .k_i     (k_q),
    .icode_i (icode_q),
    .byte_i  (bus.imem_rdata),
    .ra_o    (w_ra),
    .rb_o    (w_rb),
    .valc_o  (w_valc)
  );

  assign bus.busy      = busy_q;
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.f_valid   = valid_q;
  assign bus.icode     = icode_q;
  assign bus.ifun      = ifun_q;
  assign bus.rA        = w_ra;
  assign bus.rB        = w_rb;
  assign bus.valC      = w_valc;
  assign bus.valP      = valp_q;
  assign bus.status    = status_q;

endmodule
`default_nettype wire

// File: tb/tb_fetch_seq.sv
`default_nettype none
// ----------------------------------------------------------------------
// tb_fetch_seq : directed fetch scenarios against a behavioural model
// Rev 1.0
// ----------------------------------------------------------------------
module tb_fetch_seq;
  import y86_pkg::*;

  localparam int IMEM = 4096;

  typedef struct {
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [3:0]  ra;
    logic [3:0]  rb;
    logic [63:0] valc;
    logic [63:0] valp;
    logic [1:0]  status;
  } res_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_seq_if bus();

  fetch_seq #(.IMEM_SIZE(IMEM)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [7:0]  mem [0:IMEM-1];
  res_t        exp_r;
  logic [63:0] exp_addrs [$];
  int          req_idx;
  int          wcnt;
  int          delay;
  bit          active;

  // Instruction-set tables: max legal ifun (-1 = illegal icode), length, register byte
  int maxf   [16] = '{0, 0, 6, 0, 0, 0, 3, 6, 0, 0, 0, 0, -1, -1, -1, -1};
  int lenof  [16] = '{1, 1, 2, 10, 10, 10, 2, 9, 9, 1, 2, 2, 1, 1, 1, 1};
  bit hasreg [16] = '{0, 0, 1, 1, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0, 0, 0};

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
    end
  endtask

  function automatic void model(input logic [63:0] pc);
    logic [63:0] a;
    logic [7:0]  b;
    int          off;
    exp_addrs.delete();
    exp_r = '{icode: 4'h0, ifun: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'd0, valp: 64'd0, status: S_AOK};
    for (int k = 0; k < 10; k++) begin
      a = pc + 64'(k);
      if (a >= 64'(IMEM)) begin
        exp_r.status = S_ADR;
        exp_r.valp   = a;
        return;
      end
      exp_addrs.push_back(a);
      b = mem[a[11:0]];
      if (k == 0) begin
        exp_r.icode = b[7:4];
        exp_r.ifun  = b[3:0];
        if (int'(b[3:0]) > maxf[b[7:4]]) begin
          exp_r.status = S_INS;
          exp_r.valp   = pc + 64'd1;
          return;
        end
      end else if (hasreg[exp_r.icode] && k == 1) begin
        exp_r.ra = b[7:4];
        exp_r.rb = b[3:0];
      end else begin
        off = hasreg[exp_r.icode] ? 2 : 1;
        exp_r.valc[8*(k-off) +: 8] = b;
      end
      if (k + 1 == lenof[exp_r.icode]) begin
        exp_r.valp   = pc + 64'(k + 1);
        exp_r.status = (exp_r.icode == 4'h0) ? S_HLT : S_AOK;
        return;
      end
    end
  endfunction

  // Memory responder plus per-cycle output check against the model
  always @(negedge clk) begin
    if (rst || !active) begin
      bus.imem_ack = 1'b0;
      req_idx = 0;
      wcnt    = 0;
      if (!rst) chk("req_while_idle", 64'(bus.imem_req), 64'd0);
    end else begin
      if (bus.imem_req) begin
        chk("req_within_plan", 64'(req_idx < exp_addrs.size()), 64'd1);
        if (req_idx < exp_addrs.size())
          chk("imem_addr", bus.imem_addr, exp_addrs[req_idx]);
        if (wcnt < delay) begin
          bus.imem_ack = 1'b0;
          wcnt++;
        end else begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = mem[bus.imem_addr[11:0]];
          wcnt = 0;
          req_idx++;
        end
      end else begin
        bus.imem_ack = 1'b0;
      end
      if (bus.f_valid) begin
        chk("busy_in_done", 64'(bus.busy), 64'd1);
        chk("icode",  64'(bus.icode),  64'(exp_r.icode));
        chk("ifun",   64'(bus.ifun),   64'(exp_r.ifun));
        chk("rA",     64'(bus.rA),     64'(exp_r.ra));
        chk("rB",     64'(bus.rB),     64'(exp_r.rb));
        chk("valC",   bus.valC,        exp_r.valc);
        chk("valP",   bus.valP,        exp_r.valp);
        chk("status", 64'(bus.status), 64'(exp_r.status));
        chk("req_count", 64'(req_idx), 64'(exp_addrs.size()));
      end
    end
  end

  task automatic put(input int a, input int n, input logic [79:0] b);
    for (int i = 0; i < n; i++) mem[a + i] = b[8*i +: 8];
  endtask

  task automatic do_fetch(input logic [63:0] pc, input int dly, input bit hold);
    int cnt;
    bit got;
    @(negedge clk);
    delay = dly;
    model(pc);
    active      = 1'b1;
    bus.pc_in   = pc;
    bus.start   = 1'b1;
    bus.f_ready = !hold;
    @(posedge clk);
    #1 bus.start = 1'b0;
    cnt = 0;
    got = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (i == 0) chk("busy_after_start", 64'(bus.busy), 64'd1);
      if (bus.f_valid) begin
        got = 1'b1;
        break;
      end
      cnt++;
    end
    chk("f_valid_seen", 64'(got), 64'd1);
    chk("latency", 64'(cnt), 64'(exp_addrs.size() * (dly + 1)));
    if (hold) begin
      for (int i = 0; i < 5; i++) begin
        bus.start = 1'b1;
        bus.pc_in = pc + 64'h100;
        @(negedge clk);
        chk("hold_valid", 64'(bus.f_valid), 64'd1);
        chk("hold_req",   64'(bus.imem_req), 64'd0);
      end
      bus.start   = 1'b0;
      bus.f_ready = 1'b1;
    end
    @(posedge clk);
    #1 active = 1'b0;
    @(negedge clk);
    chk("valid_after_xfer", 64'(bus.f_valid), 64'd0);
    chk("busy_after_xfer",  64'(bus.busy),    64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen;
    rst         = 1'b1;
    active      = 1'b0;
    delay       = 0;
    bus.start   = 1'b0;
    bus.pc_in   = 64'd0;
    bus.f_ready = 1'b1;
    for (int i = 0; i < IMEM; i++) mem[i] = 8'h00;
    put(12'h000, 10, 80'h0000_0000_0000_000A_F230);
    put(12'h020,  9, 80'h0000_0000_0012_3456_7880);
    put(12'h040,  1, 80'h0);
    put(12'h050,  1, 80'hC0);
    put(12'h060,  1, 80'h27);
    put(12'h070,  2, 80'h1260);
    put(12'h080,  9, 80'h0001_2345_6789_ABCD_EF76);
    put(12'h0A0,  1, 80'h64);
    put(12'h0A8,  1, 80'h11);
    put(12'h0B0,  1, 80'h90);
    put(12'h0C0,  2, 80'h4FA0);
    put(12'h0D0, 10, 80'h0000_0000_0000_1000_1350);
    put(12'h200, 10, 80'h0000_0000_0000_0000_1240);
    put(IMEM - 4, 4, 80'h2211_F130);

    repeat (3) @(negedge clk);
    chk("rst_busy",   64'(bus.busy),     64'd0);
    chk("rst_req",    64'(bus.imem_req), 64'd0);
    chk("rst_valid",  64'(bus.f_valid),  64'd0);
    chk("rst_addr",   bus.imem_addr,     64'd0);
    chk("rst_icode",  64'(bus.icode),    64'd0);
    chk("rst_rA",     64'(bus.rA),       64'hF);
    chk("rst_rB",     64'(bus.rB),       64'hF);
    chk("rst_valC",   bus.valC,          64'd0);
    chk("rst_valP",   bus.valP,          64'd0);
    chk("rst_status", 64'(bus.status),   64'd0);
    rst = 1'b0;

    do_fetch(64'h0, 0, 1'b0);
    chk("t1_model_reqs", 64'(exp_addrs.size()), 64'd10);
    chk("t1_icode",  64'(bus.icode),  64'h3);
    chk("t1_rA",     64'(bus.rA),     64'hF);
    chk("t1_rB",     64'(bus.rB),     64'h2);
    chk("t1_valC",   bus.valC,        64'hA);
    chk("t1_valP",   bus.valP,        64'hA);
    chk("t1_status", 64'(bus.status), 64'(S_AOK));

    do_fetch(64'h20, 2, 1'b0);
    chk("t2_valC", bus.valC,      64'h1234_5678);
    chk("t2_rA",   64'(bus.rA),   64'hF);
    chk("t2_rB",   64'(bus.rB),   64'hF);
    chk("t2_valP", bus.valP,      64'h29);

    do_fetch(64'h40, 0, 1'b0);
    chk("halt_model_reqs", 64'(exp_addrs.size()), 64'd1);
    chk("halt_status", 64'(bus.status), 64'(S_HLT));
    chk("halt_valP",   bus.valP,        64'h41);

    do_fetch(64'h50, 0, 1'b0);
    chk("c0_status", 64'(bus.status), 64'(S_INS));
    chk("c0_valP",   bus.valP,        64'h51);

    do_fetch(64'h60, 1, 1'b0);
    chk("ifun7_status", 64'(bus.status), 64'(S_INS));
    chk("ifun7_ifun",   64'(bus.ifun),   64'h7);

    do_fetch(64'(IMEM - 4), 1, 1'b0);
    chk("adr_model_reqs", 64'(exp_addrs.size()), 64'd4);
    chk("adr_status", 64'(bus.status), 64'(S_ADR));
    chk("adr_valP",   bus.valP,        64'(IMEM));
    chk("adr_valC",   bus.valC,        64'h2211);

    do_fetch(64'h70, 0, 1'b1);
    chk("hold_rA",   64'(bus.rA), 64'h1);
    chk("hold_rB",   64'(bus.rB), 64'h2);
    chk("hold_valP", bus.valP,    64'h72);

    do_fetch(64'h80, 1, 1'b0);
    chk("jxx_valC", bus.valC, 64'h0123_4567_89AB_CDEF);
    chk("jxx_valP", bus.valP, 64'h89);

    do_fetch(64'hA0, 0, 1'b0);
    chk("opq4_status", 64'(bus.status), 64'(S_INS));
    do_fetch(64'hA8, 0, 1'b0);
    chk("nop1_status", 64'(bus.status), 64'(S_INS));
    do_fetch(64'hB0, 0, 1'b0);
    chk("ret_valP", bus.valP, 64'hB1);
    do_fetch(64'hC0, 0, 1'b0);
    chk("push_rA", 64'(bus.rA), 64'h4);
    do_fetch(64'hD0, 0, 1'b0);
    chk("mrm_valC", bus.valC, 64'h1000);
    do_fetch(64'h1000, 0, 1'b0);
    chk("oob_status", 64'(bus.status), 64'(S_ADR));
    do_fetch(64'hFFFF_FFFF_FFFF_FFFF, 0, 1'b0);
    chk("wrap_valP", bus.valP, 64'hFFFF_FFFF_FFFF_FFFF);

    // Reset while byte 3 of an rmmovq is on the bus
    @(negedge clk);
    delay       = 0;
    model(64'h200);
    active      = 1'b1;
    bus.pc_in   = 64'h200;
    bus.start   = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(negedge clk);
    chk("mid_addr", bus.imem_addr, 64'h203);
    rst    = 1'b1;
    active = 1'b0;
    @(negedge clk);
    chk("mid_rst_req",    64'(bus.imem_req), 64'd0);
    chk("mid_rst_busy",   64'(bus.busy),     64'd0);
    chk("mid_rst_icode",  64'(bus.icode),    64'd0);
    chk("mid_rst_rA",     64'(bus.rA),       64'hF);
    chk("mid_rst_rB",     64'(bus.rB),       64'hF);
    chk("mid_rst_valC",   bus.valC,          64'd0);
    chk("mid_rst_valP",   bus.valP,          64'd0);
    chk("mid_rst_addr",   bus.imem_addr,     64'd0);
    rst  = 1'b0;
    seen = 1'b0;
    repeat (15) begin
      @(negedge clk);
      if (bus.f_valid) seen = 1'b1;
    end
    chk("mid_rst_no_valid", 64'(seen), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
